// File: rtl/bubble_pkg.sv
// ----------------------------------------------------------------------------
// bubble_pkg: shared constants and types for the bubble output buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bubble_pkg;

  localparam logic [2:0] ACCTYPE_BOOT = 3'b110;
  localparam logic [2:0] ACCTYPE_USER = 3'b111;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_PAGE_W = 10;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/bubble_tick_sync.sv
// ----------------------------------------------------------------------------
// bubble_tick_sync: two-flop synchroniser plus rising-edge detector.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bubble_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  output logic strobe
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= tick;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync3 is the history flop: one strobe per rising edge of the tick
  assign strobe = sync2 & ~sync3;

endmodule

`default_nettype wire

// File: rtl/bubble_outbuf_nch.sv
// ----------------------------------------------------------------------------
// bubble_outbuf_nch: N-channel bubble DOUT replay buffer with post-reset clear.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bubble_outbuf_nch
  import bubble_pkg::*;
#(
  parameter int   CHANNELS  = 2,
  parameter int   ADDR_W    = DEF_ADDR_W,
  parameter int   PAGE_W    = DEF_PAGE_W,
  parameter logic CLEAR_VAL = 1'b1
) (
  input  logic                MCLK,
  input  logic                nRESET,
  input  logic                BITWIDTH4,
  input  logic [2:0]          ACCTYPE,
  input  logic [ADDR_W-1:0]   BOUTCYCLENUM,
  input  logic [1:0]          BOUTTICKS,
  input  logic                nOUTBUFWCLKEN,
  input  logic [ADDR_W+1:0]   OUTBUFWADDR,
  input  logic                OUTBUFWDATA,
  output logic [CHANNELS-1:0] DOUT,
  output logic                BUSY,
  output logic                WRDROP
);

  localparam int DEPTH = 1 << ADDR_W;

  clr_state_t        state;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] clr_row;
  logic              clearing;

  logic              mode4;
  logic              wr_req;
  logic [1:0]        wr_chan;
  logic [ADDR_W-1:0] wr_row;
  logic [ADDR_W-1:0] rd_row;
  logic              strobe;
  logic              rd_en;
  logic              wrdrop_q;

  // BOUTTICKS[0] is synchronised by another instance outside this block
  logic unused_ok;
  assign unused_ok = ^{BOUTTICKS[0], OUTBUFWADDR[ADDR_W+1]};

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state   <= CLEAR;
      clr_row <= '0;
    end else begin
      state <= state_next;
      if (clearing) begin
        clr_row <= clr_row + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    if ((state == CLEAR) && (clr_row == '1)) begin
      state_next = READY;
    end
  end

  always_comb begin
    clearing = (state == CLEAR);
  end

  assign BUSY = clearing;

  // ---------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------
  assign mode4  = (CHANNELS == 4) && BITWIDTH4;
  assign wr_req = ~nOUTBUFWCLKEN;

  always_comb begin
    if (mode4) begin
      wr_chan = OUTBUFWADDR[1:0];
      wr_row  = OUTBUFWADDR[ADDR_W+1:2];
    end else begin
      wr_chan = {1'b0, OUTBUFWADDR[0]};
      wr_row  = OUTBUFWADDR[ADDR_W:1];
    end
  end

  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      wrdrop_q <= 1'b0;
    end else begin
      wrdrop_q <= clearing & wr_req;
    end
  end

  assign WRDROP = wrdrop_q;

  // ---------------------------------------------------------------------
  // Read tick and address decode
  // ---------------------------------------------------------------------
  bubble_tick_sync u_rd_tick (
    .clk    (MCLK),
    .rst_n  (nRESET),
    .tick   (BOUTTICKS[1]),
    .strobe (strobe)
  );

  assign rd_en = strobe & ~clearing;

  // Idle access points at the last row, which holds the empty propagation line
  always_comb begin
    if (ACCTYPE == ACCTYPE_BOOT) begin
      rd_row = BOUTCYCLENUM;
    end else if (ACCTYPE == ACCTYPE_USER) begin
      rd_row = {{(ADDR_W-PAGE_W){1'b1}}, BOUTCYCLENUM[PAGE_W-1:0]};
    end else begin
      rd_row = '1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel block RAMs
  // ---------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic              mem [0:DEPTH-1];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              wdata;
    logic              active;
    logic              q;

    assign active = (c < 2) || mode4;
    assign we     = clearing || (wr_req && (wr_chan == 2'(c)));
    assign waddr  = clearing ? clr_row : wr_row;
    assign wdata  = clearing ? CLEAR_VAL : OUTBUFWDATA;

    always_ff @(posedge MCLK) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end

    // Upper channels in 2-bit mode reload the no-bubble value on each read
    always_ff @(posedge MCLK) begin
      if (!nRESET) begin
        q <= CLEAR_VAL;
      end else if (rd_en) begin
        q <= active ? mem[rd_row] : CLEAR_VAL;
      end
    end

    assign DOUT[c] = ~q;
  end

endmodule

`default_nettype wire
